// File: rtl/firmware_loader_if.sv
// Byte-stream input and firmware-store write port of the firmware loader.
// master: byte source / observer side; slave: the loader itself.
interface firmware_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] wr_address;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_address, wr_data, wr_en, busy, done, error
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_address, wr_data, wr_en, busy, done, error
  );
endinterface

// File: rtl/firmware_loader_m.sv
// Parses HEADER/ADDR/LEN/payload records and writes payload into the firmware store.
// Optional trailing checksum byte enabled by defining FIRMWARE_LOADER_CHECKSUM_EN.
module firmware_loader_m #(
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int unsigned MEM_BYTES = 16384
) (
  input logic              clk,
  input logic              rst_n,
  firmware_loader_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrLo,
    StAddrHi,
    StLenLo,
    StLenHi,
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    StData,
    StCsum
`else
    StData
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] addr_q, addr_d;
  logic [15:0] len_q, len_d;
  logic [15:0] len_full;
  logic        ready_q;
  logic        wr_en_q, wr_en_d;
  logic [13:0] wr_address_q, wr_address_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  csum_sum;
`endif

  assign accept = bus.in_valid & ready_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    len_full     = {bus.in_data, len_q[7:0]};
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    csum_sum     = csum_q + bus.in_data;
    if (accept && state_q != StIdle) csum_d = csum_sum;
`endif
    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_data == HEADER) begin
            state_d = StAddrLo;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            csum_d  = 8'h00;
`endif
          end
        end
        StAddrLo: begin
          addr_d[7:0] = bus.in_data;
          state_d     = StAddrHi;
        end
        StAddrHi: begin
          // Store is 16 KiB: any of ADDR[15:14] set is out of range.
          if (bus.in_data[7:6] != 2'b00) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d[13:8] = bus.in_data[5:0];
            state_d      = StLenLo;
          end
        end
        StLenLo: begin
          len_d[7:0] = bus.in_data;
          state_d    = StLenHi;
        end
        StLenHi: begin
          len_d = len_full;
          if (32'(len_full) > MEM_BYTES) begin
            error_d = 1'b1;
            state_d = StIdle;
          end else if (len_full == 16'd0) begin
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            done_d  = 1'b1;
            state_d = StIdle;
`endif
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          wr_en_d      = 1'b1;
          wr_address_d = addr_q;
          wr_data_d    = bus.in_data;
          addr_d       = addr_q + 14'd1;
          len_d        = len_q - 16'd1;
          if (len_q == 16'd1) begin
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            done_d  = 1'b1;
            state_d = StIdle;
`endif
          end
        end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
        StCsum: begin
          done_d  = (csum_sum == 8'h00);
          error_d = (csum_sum != 8'h00);
          state_d = StIdle;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      ready_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      ready_q      <= 1'b1;
      wr_en_q      <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_address = wr_address_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_firmware_loader_m.sv
// Directed bench for firmware_loader_m: record parsing, address wrap, error paths,
// mid-record reset and input gaps. Follows FIRMWARE_LOADER_CHECKSUM_EN like the RTL.
module tb_firmware_loader_m;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  firmware_loader_if bus ();

  firmware_loader_m #(
    .HEADER   (8'hA5),
    .MEM_BYTES(16384)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Write/pulse monitor, sampled on the falling edge.
  logic [13:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          done_n = 0;
  int          err_n  = 0;
  int          both_n = 0;
  int          cyc    = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (bus.wr_en) begin
        wa.push_back(bus.wr_address);
        wd.push_back(bus.wr_data);
        wc.push_back(cyc);
      end
      if (bus.done) done_n++;
      if (bus.error) err_n++;
      if (bus.done && bus.error) both_n++;
    end
  end

  logic [7:0] pay[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checksum byte makes the 8-bit sum of ADDR..LEN, payload and CSUM equal zero.
  task automatic send_rec(input logic [15:0] addr, input logic [15:0] len,
                          input logic [7:0] adj, input int gap);
    logic [7:0] s;
    s = addr[7:0] + addr[15:8] + len[7:0] + len[15:8];
    send(8'hA5);
    send(addr[7:0]);
    send(addr[15:8]);
    send(len[7:0]);
    send(len[15:8]);
    for (int i = 0; i < int'(len); i++) begin
      s = s + pay[i];
      send(pay[i]);
      if (gap > 0 && i < int'(len) - 1) idle(gap);
    end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    send(8'(8'h00 - s) + adj);
`else
    if (adj != 8'h00) $display("[TB] checksum adjust ignored in this build");
`endif
  endtask

  task automatic check_writes(input string tag, input int base, input int n,
                              input logic [13:0] a0, input bit b2b);
    logic [13:0] ea;
    check({tag, "_count"}, 32'(wa.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < wa.size(); i++) begin
      ea = a0 + 14'(i);
      check({tag, "_addr"}, 32'(wa[base+i]), 32'(ea));
      check({tag, "_data"}, 32'(wd[base+i]), 32'(pay[i]));
      if (b2b && i > 0) check({tag, "_b2b"}, 32'(wc[base+i] - wc[base+i-1]), 32'd1);
    end
  endtask

  int base, d0, e0;

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset with stream idle.
    idle(3);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_address", 32'(bus.wr_address), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(bus.in_ready), 32'd1);
    check("busy_after_rst", 32'(bus.busy), 32'd0);

    // Basic record: 0x1000 <= 11 22 33.
    base = wa.size(); d0 = done_n; e0 = err_n;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send(8'hA5);
    check("busy_after_hdr", 32'(bus.busy), 32'd1);
    send(8'h00); send(8'h10); send(8'h03); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33);
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    send(8'h87);
`endif
    check("a_done_pulse", 32'(bus.done), 32'd1);
    check("a_busy_low", 32'(bus.busy), 32'd0);
    idle(2);
    check("a_done_gone", 32'(bus.done), 32'd0);
    check_writes("a_wr", base, 3, 14'h1000, 1'b1);
    check("a_done_cnt", 32'(done_n - d0), 32'd1);
    check("a_err_cnt", 32'(err_n - e0), 32'd0);

    // Address wraps from 0x3FFF to 0x0000.
    base = wa.size(); d0 = done_n; e0 = err_n;
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_rec(16'h3FFF, 16'd2, 8'h00, 0);
    idle(2);
    check("wrap_wr_count", 32'(wa.size() - base), 32'd2);
    if (wa.size() - base == 2) begin
      check("wrap_addr0", 32'(wa[base]), 32'h3FFF);
      check("wrap_addr1", 32'(wa[base+1]), 32'h0000);
      check("wrap_data1", 32'(wd[base+1]), 32'hBB);
    end
    check("wrap_done_cnt", 32'(done_n - d0), 32'd1);

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    // Bad checksum: writes stay, error instead of done.
    base = wa.size(); d0 = done_n; e0 = err_n;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_rec(16'h1000, 16'd3, 8'h01, 0);
    check("badcs_error", 32'(bus.error), 32'd1);
    idle(2);
    check_writes("badcs_wr", base, 3, 14'h1000, 1'b1);
    check("badcs_done_cnt", 32'(done_n - d0), 32'd0);
    check("badcs_err_cnt", 32'(err_n - e0), 32'd1);
`endif

    // LEN one past the store size is rejected.
    base = wa.size(); d0 = done_n; e0 = err_n;
    send(8'hA5); send(8'h00); send(8'h00); send(8'h01); send(8'h40);
    check("len_err_pulse", 32'(bus.error), 32'd1);
    check("len_err_busy", 32'(bus.busy), 32'd0);
    idle(2);
    check("len_err_writes", 32'(wa.size() - base), 32'd0);
    check("len_err_done_cnt", 32'(done_n - d0), 32'd0);

    // LEN = 0 completes without writes.
    base = wa.size(); d0 = done_n;
    send_rec(16'h2000, 16'd0, 8'h00, 0);
    check("len0_done", 32'(bus.done), 32'd1);
    idle(2);
    check("len0_writes", 32'(wa.size() - base), 32'd0);

    // Leading junk then ADDR_HI out of range, followed by a good record.
    base = wa.size(); d0 = done_n; e0 = err_n;
    send(8'h00); send(8'hFF);
    check("junk_not_busy", 32'(bus.busy), 32'd0);
    send(8'hA5); send(8'h00); send(8'h40);
    check("addrhi_err_pulse", 32'(bus.error), 32'd1);
    check("addrhi_err_done", 32'(bus.done), 32'd0);
    idle(2);
    check("addrhi_writes", 32'(wa.size() - base), 32'd0);
    check("addrhi_err_cnt", 32'(err_n - e0), 32'd1);
    base = wa.size();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_rec(16'h1000, 16'd3, 8'h00, 0);
    idle(2);
    check_writes("after_err_wr", base, 3, 14'h1000, 1'b1);
    check("after_err_done_cnt", 32'(done_n - d0), 32'd1);

    // Reset after the second payload byte of a 3-byte record.
    base = wa.size(); d0 = done_n;
    pay[0] = 8'h44; pay[1] = 8'h55; pay[2] = 8'h66;
    send(8'hA5); send(8'h00); send(8'h05); send(8'h03); send(8'h00);
    send(8'h44); send(8'h55);
    #6;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    bus.in_data  = 8'h66;
    bus.in_valid = 1'b1;
    idle(2);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready_back", 32'(bus.in_ready), 32'd1);
    idle(2);
    check_writes("midrst_wr", base, 2, 14'h0500, 1'b1);
    check("midrst_done_cnt", 32'(done_n - d0), 32'd0);

    // Next record with idle gaps between payload bytes.
    base = wa.size(); d0 = done_n; e0 = err_n;
    pay[0] = 8'h77; pay[1] = 8'h88; pay[2] = 8'h99;
    send_rec(16'h0123, 16'd3, 8'h00, 3);
    idle(3);
    check_writes("gap_wr", base, 3, 14'h0123, 1'b0);
    check("gap_done_cnt", 32'(done_n - d0), 32'd1);
    check("gap_err_cnt", 32'(err_n - e0), 32'd0);

    check("done_error_exclusive", 32'(both_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
